gs_prefetch_buf: RTL

GS_PREFETCH_BUF -- requirements
Module: gs_prefetch_buf

---
 rtl/gs_pkg.sv | 11 +
 rtl/gs_fifo.sv | 51 +++++
 rtl/gs_prefetch_buf.sv | 119 +++++++++++
 3 files changed

// File: rtl/gs_pkg.sv
// Shared control types for the GS front-end blocks.
package gs_pkg;

  typedef enum logic [4:0] {
    INITIAL  = 5'd0,
    FETCHING = 5'd1,
    PENDING  = 5'd2,
    HALTED   = 5'd3
  } pf_state_t;

endpackage

// File: rtl/gs_fifo.sv
// Power-of-two circular FIFO with registered storage, combinational head and a
// synchronous flush that empties it in one cycle.
module gs_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push_i) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop_i)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only; it is never reset and only the pointers qualify it.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) r_mem[r_wr_ptr] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/gs_prefetch_buf.sv
// Instruction prefetcher: one outstanding fetch at a time into a small FIFO,
// with redirect handling that discards a response already in flight.
module gs_prefetch_buf
  import gs_pkg::*;
#(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  input  logic                  rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] rsp_data_i,
  input  logic                  rsp_err_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_data_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_err_o,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] flush_addr_i,
  output pf_state_t             state_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  pf_state_t             r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nx, r_req_pc;
  logic                  r_drop, w_drop_nx;
  logic                  w_push, w_pop, w_hs, w_nonempty;
  logic [CW-1:0]         w_count;
  logic [EW-1:0]         w_head;

  gs_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .wdata_i ({r_req_pc, rsp_data_i, rsp_err_i}),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .rdata_o (w_head),
    .count_o (w_count)
  );

  assign w_nonempty    = (w_count != '0);
  assign req_valid_o   = (r_state == FETCHING) && (w_count < FULL_C);
  assign req_addr_o    = r_pc;
  assign w_hs          = req_valid_o && req_ready_i;
  assign instr_valid_o = w_nonempty && !flush_i;
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign instr_addr_o  = w_head[EW-1 -: ADDR_WIDTH];
  assign instr_data_o  = w_head[DATA_WIDTH:1];
  // Gated so stale, unreset storage never shows an error flag while empty.
  assign instr_err_o   = w_head[0] && w_nonempty;
  assign state_o       = r_state;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_drop_nx  = r_drop;
    w_push     = 1'b0;
    if (flush_i) begin
      w_pc_nx = flush_addr_i;
      // A request that is (or is becoming) outstanding still owes one response.
      if ((r_state == FETCHING && w_hs) || (r_state == PENDING && !rsp_valid_i)) begin
        w_state_nx = PENDING;
        w_drop_nx  = 1'b1;
      end else begin
        w_state_nx = FETCHING;
        w_drop_nx  = 1'b0;
      end
    end else begin
      case (r_state)
        INITIAL:  w_state_nx = FETCHING;
        FETCHING: begin
          if (w_hs) begin
            w_state_nx = PENDING;
            w_pc_nx    = r_pc + ADDR_WIDTH'(4);
          end
        end
        PENDING: begin
          if (rsp_valid_i) begin
            w_state_nx = FETCHING;
            if (r_drop) begin
              w_drop_nx = 1'b0;
            end else begin
              w_push = 1'b1;
              if (rsp_err_i) w_state_nx = HALTED;
            end
          end
        end
        HALTED:   w_state_nx = HALTED;
        default:  w_state_nx = INITIAL;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= INITIAL;
      r_pc    <= BOOT_ADDR;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_drop  <= w_drop_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs) r_req_pc <= r_pc;
  end

endmodule
